// File: rtl/lab2_proc_test_mem_responder.sv
// Test memory responder: val/rdy request in, val/rdy response out after p_latency cycles, backed by a word array.
// Latency: p_latency cycles from accept to response valid; one request in flight, pass-through at p_latency==1.
// Backpressure: respstream_rdy low holds the response stable and keeps reqstream_rdy low. Optional stats: LAB2_PROC_TEST_MEM_STATS_EN.
module lab2_proc_test_mem_responder #(
    parameter int p_num_words = 1024,
    parameter int p_latency   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqstream_val,
    output logic        reqstream_rdy,
    input  logic [2:0]  reqstream_type,
    input  logic [7:0]  reqstream_opaque,
    input  logic [31:0] reqstream_addr,
    input  logic [1:0]  reqstream_len,
    input  logic [31:0] reqstream_data,
    output logic        respstream_val,
    input  logic        respstream_rdy,
    output logic [2:0]  respstream_type,
    output logic [7:0]  respstream_opaque,
    output logic [1:0]  respstream_len,
    output logic [31:0] respstream_data
`ifdef LAB2_PROC_TEST_MEM_STATS_EN
    ,
    output logic [31:0] num_reads,
    output logic [31:0] num_writes,
    output logic [31:0] num_stall_cycles
`endif
);

    localparam int AW = $clog2(p_num_words);
    localparam int CW = (p_latency > 1) ? $clog2(p_latency) : 1;

    typedef enum logic [1:0] {IDLE, DELAY, RESP} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    resp_type_q;
    logic [7:0]    resp_opaque_q;
    logic [1:0]    resp_len_q;
    logic [31:0]   resp_data_q;

    logic [31:0]   mem_q [p_num_words];

    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic          is_write;
    logic          accept;
    logic [2:0]    nbytes;
    logic [2:0]    pos;
    logic [31:0]   rd_word;
    logic [31:0]   rd_data_d;
    logic [31:0]   wr_word_d;
    logic          unused_addr_bits;

    assign widx             = reqstream_addr[AW+1:2];
    assign lane             = reqstream_addr[1:0];
    assign unused_addr_bits = ^reqstream_addr[31:AW+2];
    assign is_write         = (reqstream_type == 3'd1) || (reqstream_type == 3'd2);
    assign nbytes           = (reqstream_len == 2'd0) ? 3'd4 : {1'b0, reqstream_len};
    assign rd_word          = mem_q[widx];

    // Pass-through only at unit latency: the slot frees on the same edge the response leaves.
    assign reqstream_rdy = reset && ((state_q == IDLE) ||
                           ((p_latency == 1) && (state_q == RESP) && respstream_rdy));
    assign accept        = reqstream_val && reqstream_rdy;

    assign respstream_val    = (state_q == RESP);
    assign respstream_type   = resp_type_q;
    assign respstream_opaque = resp_opaque_q;
    assign respstream_len    = resp_len_q;
    assign respstream_data   = resp_data_q;

    // Byte i of the request maps to byte lane+i of the word; lanes past byte 3 are dropped.
    always_comb begin
        rd_data_d = '0;
        wr_word_d = rd_word;
        pos       = '0;
        for (int i = 0; i < 4; i++) begin
            pos = {1'b0, lane} + 3'(i);
            if ((3'(i) < nbytes) && (pos < 3'd4)) begin
                rd_data_d[8*i +: 8]            = rd_word[{pos[1:0], 3'b000} +: 8];
                wr_word_d[{pos[1:0], 3'b000} +: 8] = reqstream_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && is_write) begin
            mem_q[widx] <= wr_word_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            resp_type_q   <= '0;
            resp_opaque_q <= '0;
            resp_len_q    <= '0;
            resp_data_q   <= '0;
        end else if (accept) begin
            resp_type_q   <= reqstream_type;
            resp_opaque_q <= reqstream_opaque;
            resp_len_q    <= reqstream_len;
            resp_data_q   <= is_write ? 32'd0 : rd_data_d;
            cnt_q         <= CW'(p_latency - 1);
            state_q       <= (p_latency == 1) ? RESP : DELAY;
        end else begin
            case (state_q)
                DELAY: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (respstream_rdy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LAB2_PROC_TEST_MEM_STATS_EN
    logic [31:0] num_reads_q;
    logic [31:0] num_writes_q;
    logic [31:0] num_stall_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            num_reads_q  <= '0;
            num_writes_q <= '0;
            num_stall_q  <= '0;
        end else begin
            if (accept && !is_write) num_reads_q  <= num_reads_q + 32'd1;
            if (accept && is_write)  num_writes_q <= num_writes_q + 32'd1;
            if (respstream_val && !respstream_rdy) num_stall_q <= num_stall_q + 32'd1;
        end
    end

    assign num_reads        = num_reads_q;
    assign num_writes       = num_writes_q;
    assign num_stall_cycles = num_stall_q;
`endif

endmodule

// File: tb/tb_lab2_proc_test_mem_responder.sv
// Bench for lab2_proc_test_mem_responder: a unit-latency instance (dut0) and a 3-cycle instance (dut1)
// share clock and reset; responses are checked against a scoreboard queue filled at request accept.
module tb_lab2_proc_test_mem_responder;

    localparam int L0 = 1;
    localparam int L1 = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        q_val  [2];
    logic        q_rdy  [2];
    logic [2:0]  q_type [2];
    logic [7:0]  q_opq  [2];
    logic [31:0] q_addr [2];
    logic [1:0]  q_len  [2];
    logic [31:0] q_data [2];
    logic        p_val  [2];
    logic        p_rdy  [2];
    logic [2:0]  p_type [2];
    logic [7:0]  p_opq  [2];
    logic [1:0]  p_len  [2];
    logic [31:0] p_data [2];
`ifdef LAB2_PROC_TEST_MEM_STATS_EN
    logic [31:0] n_rd [2];
    logic [31:0] n_wr [2];
    logic [31:0] n_st [2];
`endif

    typedef struct {
        logic [2:0]  t;
        logic [7:0]  o;
        logic [1:0]  l;
        logic [31:0] d;
        int          acc;
    } exp_t;

    exp_t        eq0[$];
    exp_t        eq1[$];
    logic [31:0] mdl [2][1024];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          nrd [2] = '{0, 0};
    int          nwr [2] = '{0, 0};
    int          stall_cnt [2] = '{0, 0};
    int          start [2] = '{0, 0};
    bit          newr [2] = '{1'b1, 1'b1};
    bit          rnd_rdy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lab2_proc_test_mem_responder #(.p_num_words(1024), .p_latency(L0)) dut0 (
        .clk(clk), .reset(reset),
        .reqstream_val(q_val[0]), .reqstream_rdy(q_rdy[0]), .reqstream_type(q_type[0]),
        .reqstream_opaque(q_opq[0]), .reqstream_addr(q_addr[0]), .reqstream_len(q_len[0]),
        .reqstream_data(q_data[0]),
        .respstream_val(p_val[0]), .respstream_rdy(p_rdy[0]), .respstream_type(p_type[0]),
        .respstream_opaque(p_opq[0]), .respstream_len(p_len[0]), .respstream_data(p_data[0])
`ifdef LAB2_PROC_TEST_MEM_STATS_EN
        , .num_reads(n_rd[0]), .num_writes(n_wr[0]), .num_stall_cycles(n_st[0])
`endif
    );

    lab2_proc_test_mem_responder #(.p_num_words(1024), .p_latency(L1)) dut1 (
        .clk(clk), .reset(reset),
        .reqstream_val(q_val[1]), .reqstream_rdy(q_rdy[1]), .reqstream_type(q_type[1]),
        .reqstream_opaque(q_opq[1]), .reqstream_addr(q_addr[1]), .reqstream_len(q_len[1]),
        .reqstream_data(q_data[1]),
        .respstream_val(p_val[1]), .respstream_rdy(p_rdy[1]), .respstream_type(p_type[1]),
        .respstream_opaque(p_opq[1]), .respstream_len(p_len[1]), .respstream_data(p_data[1])
`ifdef LAB2_PROC_TEST_MEM_STATS_EN
        , .num_reads(n_rd[1]), .num_writes(n_wr[1]), .num_stall_cycles(n_st[1])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? eq0.size() : eq1.size();
    endfunction

    function automatic exp_t qfront(input int d);
        return (d == 0) ? eq0[0] : eq1[0];
    endfunction

    task automatic qpush(input int d, input exp_t e);
        if (d == 0) eq0.push_back(e); else eq1.push_back(e);
    endtask

    task automatic qpop(input int d);
        if (d == 0) void'(eq0.pop_front()); else void'(eq1.pop_front());
    endtask

    function automatic logic [31:0] mread(input logic [31:0] w, input logic [1:0] lane, input logic [1:0] len);
        logic [31:0] r = '0;
        int n = (len == 2'd0) ? 4 : int'(len);
        for (int i = 0; i < n; i++)
            if (int'(lane) + i < 4) r[8*i +: 8] = w[8*(int'(lane) + i) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mwrite(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [1:0] len, input logic [31:0] dat);
        logic [31:0] r = w;
        int n = (len == 2'd0) ? 4 : int'(len);
        for (int i = 0; i < n; i++)
            if (int'(lane) + i < 4) r[8*(int'(lane) + i) +: 8] = dat[8*i +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) p_rdy[0] = 1'($urandom_range(0, 1));
    endtask

    // Leaves q_val high so consecutive calls form a back-to-back stream.
    task automatic send(input int d, input logic [2:0] t, input logic [7:0] o, input logic [31:0] a,
                        input logic [1:0] l, input logic [31:0] dat, input logic [31:0] exp_d);
        exp_t e;
        bit ok = 1'b0;
        bit wr = (t == 3'd1) || (t == 3'd2);
        q_type[d] = t; q_opq[d] = o; q_addr[d] = a; q_len[d] = l; q_data[d] = dat; q_val[d] = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (q_rdy[d]) begin
                ok = 1'b1;
                e.t = t; e.o = o; e.l = l; e.d = wr ? 32'd0 : exp_d; e.acc = cyc;
                qpush(d, e);
                if (wr) begin
                    mdl[d][a[11:2]] = mwrite(mdl[d][a[11:2]], a[1:0], l, dat);
                    nwr[d]++;
                end else begin
                    nrd[d]++;
                end
            end
            tick();
        end
        if (!ok) chk($sformatf("d%0d_req_timeout", d), 32'd0, 32'd1);
    endtask

    task automatic wait_drain(input int d);
        for (int n = 0; n < 200 && qsize(d) != 0; n++) tick();
        chk($sformatf("d%0d_drain", d), 32'(qsize(d)), 32'd0);
    endtask

    task automatic mon(input int d, input logic v, input logic r, input logic [2:0] t, input logic [7:0] o,
                       input logic [1:0] l, input logic [31:0] dat, input int lat);
        exp_t e;
        if (!reset) begin
            newr[d] = 1'b1;
            return;
        end
        if (!v) return;
        if (qsize(d) == 0) begin
            chk($sformatf("d%0d_spurious_resp", d), 32'd1, 32'd0);
            return;
        end
        e = qfront(d);
        if (newr[d]) begin
            start[d] = cyc;
            newr[d]  = 1'b0;
        end
        if (r) begin
            chk($sformatf("d%0d_resp_type", d), 32'(t), 32'(e.t));
            chk($sformatf("d%0d_resp_opaque", d), 32'(o), 32'(e.o));
            chk($sformatf("d%0d_resp_len", d), 32'(l), 32'(e.l));
            chk($sformatf("d%0d_resp_data", d), dat, e.d);
            chk($sformatf("d%0d_resp_latency", d), 32'(start[d] - e.acc), 32'(lat));
            qpop(d);
            newr[d] = 1'b1;
        end else begin
            stall_cnt[d]++;
            chk($sformatf("d%0d_stall_data", d), dat, e.d);
            chk($sformatf("d%0d_stall_opaque", d), 32'(o), 32'(e.o));
        end
    endtask

    always @(negedge clk) begin
        mon(0, p_val[0], p_rdy[0], p_type[0], p_opq[0], p_len[0], p_data[0], L0);
        mon(1, p_val[1], p_rdy[1], p_type[1], p_opq[1], p_len[1], p_data[1], L1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic [31:0] a;
        logic [2:0]  t;
        logic [1:0]  l;
        logic [31:0] dat;
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            q_val[d] = 1'b0; q_type[d] = '0; q_opq[d] = '0; q_addr[d] = '0;
            q_len[d] = '0; q_data[d] = '0; p_rdy[d] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_reqrdy", d), 32'(q_rdy[d]), 32'd0);
            chk($sformatf("d%0d_rst_respval", d), 32'(p_val[d]), 32'd0);
            chk($sformatf("d%0d_rst_data", d), p_data[d], 32'd0);
            chk($sformatf("d%0d_rst_opaque", d), 32'(p_opq[d]), 32'd0);
        end
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("d0_idle_reqrdy", 32'(q_rdy[0]), 32'd1);
        tick();

        // init then read, back to back
        send(0, 3'd2, 8'h01, 32'h200, 2'd0, 32'hdeadbeef, 32'd0);
        send(0, 3'd0, 8'h02, 32'h200, 2'd0, 32'd0, 32'hdeadbeef);
        q_val[0] = 1'b0;
        wait_drain(0);

        // sub-word write and lane reads
        send(0, 3'd2, 8'h03, 32'h1004, 2'd0, 32'h11223344, 32'd0);
        send(0, 3'd1, 8'h04, 32'h1004, 2'd1, 32'h000000ab, 32'd0);
        send(0, 3'd0, 8'h05, 32'h1004, 2'd0, 32'd0, 32'h112233ab);
        send(0, 3'd0, 8'h06, 32'h1006, 2'd2, 32'd0, 32'h00001122);
        send(0, 3'd0, 8'h07, 32'h1007, 2'd0, 32'd0, 32'h00000011);
        q_val[0] = 1'b0;
        wait_drain(0);

        // eight back-to-back reads
        c0 = cyc;
        for (int i = 0; i < 8; i++) send(0, 3'd0, 8'(i), 32'h200, 2'd0, 32'd0, 32'hdeadbeef);
        q_val[0] = 1'b0;
        chk("d0_burst_cycles", 32'(cyc - c0), 32'd8);
        wait_drain(0);

        // address wrap and an unused type code acting as read
        send(0, 3'd1, 8'h08, 32'h1000, 2'd0, 32'h00000055, 32'd0);
        send(0, 3'd0, 8'h09, 32'h0, 2'd0, 32'd0, 32'h00000055);
        send(0, 3'd5, 8'h0a, 32'h1000, 2'd0, 32'd0, 32'h00000055);
        q_val[0] = 1'b0;
        wait_drain(0);

        // random traffic over eight words with random response backpressure
        for (int w = 0; w < 8; w++) send(0, 3'd2, 8'(8'h40 + w), 32'hC00 + 32'(4 * w), 2'd0, $urandom, 32'd0);
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: t = 3'd0;
                1: t = 3'd1;
                2: t = 3'd2;
                default: t = 3'd6;
            endcase
            a   = 32'hC00 + 32'($urandom_range(0, 31));
            l   = 2'($urandom_range(0, 3));
            dat = $urandom;
            send(0, t, 8'(8'h80 + i), a, l, dat, mread(mdl[0][a[11:2]], a[1:0], l));
        end
        q_val[0] = 1'b0;
        wait_drain(0);
        rnd_rdy = 1'b0;
        p_rdy[0] = 1'b1;
        tick();
`ifdef LAB2_PROC_TEST_MEM_STATS_EN
        chk("d0_num_reads", n_rd[0], 32'(nrd[0]));
        chk("d0_num_writes", n_wr[0], 32'(nwr[0]));
        chk("d0_num_stall", n_st[0], 32'(stall_cnt[0]));
`endif

        // latency 3 with the response stalled for four cycles
        send(1, 3'd2, 8'h20, 32'h80, 2'd0, 32'h01020304, 32'd0);
        q_val[1] = 1'b0;
        wait_drain(1);
        p_rdy[1] = 1'b0;
        send(1, 3'd0, 8'h21, 32'h80, 2'd0, 32'd0, 32'h01020304);
        q_val[1] = 1'b0;
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 10 && !seen; n++) begin
                @(negedge clk);
                chk("d1_delay_reqrdy", 32'(q_rdy[1]), 32'd0);
                seen = p_val[1];
            end
            chk("d1_val_rise", 32'(seen), 32'd1);
        end
        repeat (3) begin
            @(negedge clk);
            chk("d1_stall_reqrdy", 32'(q_rdy[1]), 32'd0);
            chk("d1_stall_val", 32'(p_val[1]), 32'd1);
        end
        tick();
        p_rdy[1] = 1'b1;
        wait_drain(1);
`ifdef LAB2_PROC_TEST_MEM_STATS_EN
        chk("d1_num_stall", n_st[1], 32'd4);
        chk("d1_num_reads", n_rd[1], 32'd1);
        chk("d1_num_writes", n_wr[1], 32'd1);
`endif

        // reset while a read sits in DELAY: response dropped, earlier write kept
        send(1, 3'd1, 8'h22, 32'h40, 2'd0, 32'hcafef00d, 32'd0);
        send(1, 3'd0, 8'h23, 32'h40, 2'd0, 32'd0, 32'hcafef00d);
        q_val[1] = 1'b0;
        reset = 1'b0;
        eq1.delete();
        repeat (2) @(negedge clk);
        chk("d1_rstdly_val", 32'(p_val[1]), 32'd0);
        chk("d1_rstdly_reqrdy", 32'(q_rdy[1]), 32'd0);
        chk("d1_rstdly_data", p_data[1], 32'd0);
        tick();
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("d1_no_resp_after_rst", 32'(p_val[1]), 32'd0);
        end
        tick();
        send(1, 3'd0, 8'h24, 32'h40, 2'd0, 32'd0, 32'hcafef00d);
        q_val[1] = 1'b0;
        wait_drain(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lab2_proc_test_mem_responder.md
Name: lab2_proc_test_mem_responder

Overview:
- Memory-side responder for the processor's imem/dmem request/response stream ports.
- Accepts read/write/init requests over a val/rdy request stream.
- Performs the access on an internal word array and returns a response after a programmable delay over a val/rdy response stream.
- Serves as the data memory or instruction memory instance in processor test harnesses. One request is in flight at a time, with back-to-back throughput at minimum latency.

Parameters:
- p_num_words, 1024, word-array depth; must be a power of two.
- p_latency, 1, cycles from request accept to response valid; minimum 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (0 = reset asserted)
- reqstream_val  in  1  request valid
- reqstream_rdy  out  1  request ready
- reqstream_type  in  3  0=read, 1=write, 2=init
- reqstream_opaque  in  8  tag, echoed in the response
- reqstream_addr  in  32  byte address
- reqstream_len  in  2  bytes accessed; 0 means 4
- reqstream_data  in  32  write data
- respstream_val  out  1  response valid
- respstream_rdy  in  1  response ready
- respstream_type  out  3  copy of the request type
- respstream_opaque  out  8  copy of the request opaque tag
- respstream_len  out  2  copy of the request len
- respstream_data  out  32  read data; 0 for write/init

Behaviour:
- Word index = addr[log2(p_num_words)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*p_num_words.
- Byte lane = addr[1:0].
- Reads:
  - return len bytes starting at the lane, shifted to bit 0 and zero-extended;
  - bytes past the word boundary read as 0.
- Writes/init:
  - update len bytes starting at the lane from reqstream_data[8*len-1:0];
  - bytes past the word boundary are dropped;
  - other bytes are unchanged.
- Access timing: the array is read and written on the accept edge (reqstream_val & reqstream_rdy). Read data, type, opaque and len are captured into the response register on that same edge.
- FSM states IDLE, DELAY, RESP.
  - IDLE: reqstream_rdy=1. On accept, go to RESP if p_latency==1, else go to DELAY with cnt=p_latency-1.
  - DELAY: reqstream_rdy=0. cnt decrements each cycle; when cnt==1, go to RESP.
  - RESP: respstream_val=1.
    - If respstream_rdy=0: hold the state and all response fields stable.
    - If respstream_rdy=1: reqstream_rdy=1 this cycle only when p_latency==1 (pass-through). A simultaneous accept reloads the response register and the FSM behaves as on an accept from IDLE. With no new accept, go to IDLE.
- reqstream_rdy must not depend combinationally on reqstream_val. Its only combinational dependence is on respstream_rdy, in RESP with p_latency==1.
- Throughput:
  - p_latency==1: one request per cycle under continuous respstream_rdy.
  - otherwise: one request per p_latency+1 cycles.
- Reset (reset==0 at clk edge):
  - state=IDLE, cnt=0, respstream_val=0, reqstream_rdy=0 while in reset, response fields=0.
  - An in-flight request is discarded, but any write it performed remains.
  - Array contents are not reset.
- Type values 3..7 are treated as read.

Optional Feature:
- Macro LAB2_PROC_TEST_MEM_STATS_EN.
- When defined, adds three ports:
  - num_reads out 32;
  - num_writes out 32 (write + init);
  - num_stall_cycles out 32, counting cycles with respstream_val=1 & respstream_rdy=0.
- Counters increment on the accept edge (or on each stall cycle), reset to 0, and wrap at 2^32.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then init addr 0x200 data 0xdeadbeef len 0, then read 0x200 len 0 (p_latency=1) -> response type 2 data 0, then response type 0 data 0xdeadbeef opaque echoed, exactly 1 cycle after each accept.
- Write 0x1004 data 0x000000ab len 1 over a word holding 0x11223344, then read 0x1004 len 0 -> 0x112233ab. Read 0x1006 len 2 -> 0x00001122. Read 0x1007 len 0 -> 0x00000011.
- p_latency=3, read with respstream_rdy held 0 for 4 cycles after val rises -> val rises 3 cycles after accept; fields stable while stalled; reqstream_rdy=0 until the response is taken; stats num_stall_cycles=4.
- p_latency=1, 8 back-to-back reads with respstream_rdy=1 -> 8 responses in 8 consecutive cycles, opaque 0..7 in order.
- p_num_words=1024, write 0x55 to 0x1000, read addr 0x0 -> 0x55 (address wrap).
- reset=0 asserted while in DELAY -> respstream_val=0 the next cycle, no response emitted, and a prior write to the target word persists.
